// File: rtl/dpd_layer_sequencer_pkg.sv
// dpd_seq_pack: shared state encoding, layer geometry defaults and sizing helpers
package dpd_seq_pack;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
  localparam int N_FEAT = 12;
  localparam int DEF_PAR = 3;
  localparam int LAYER_SIZES [3] = '{12, 12, 2};
  // The output layer also sees the input features and the layer-0 activations
  localparam int DENSE = 24;
  localparam int DEF_FANOUT [3] = LAYER_SIZES;
  localparam int DEF_FANIN [3] = '{N_FEAT, LAYER_SIZES[0], LAYER_SIZES[1] + DENSE};
  function automatic int chunks(input int fanin, input int p);
    return (fanin + p - 1) / p;
  endfunction
  function automatic int layer_base(input int l);
    int b = 0;
    for (int k = 0; k < l; k++) b += DEF_FANOUT[k] * chunks(DEF_FANIN[k], DEF_PAR);
    return b;
  endfunction
endpackage

// File: rtl/dpd_layer_sequencer_loop_counter.sv
// dpd_loop_counter: wrap counter with enable, runtime limit and terminal flag
module dpd_loop_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_term
);
  logic [W-1:0] r_count;
  assign o_count = r_count;
  assign o_term = r_count == i_limit;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_count <= '0;
    else if (i_en) r_count <= o_term ? '0 : r_count + 1'b1;
  end
endmodule

// File: rtl/dpd_layer_sequencer.sv
// dpd_layer_sequencer: steps the shared MAC engine through every layer of one DPD sample
module dpd_layer_sequencer
  import dpd_seq_pack::*;
#(
  parameter int N_LAYERS = 3,
  parameter int FANOUT [N_LAYERS] = DEF_FANOUT,
  parameter int FANIN [N_LAYERS] = DEF_FANIN,
  parameter int PARALLEL_INPUTS = DEF_PAR,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       mac_valid,
  input  logic                       mac_ready,
  output logic [1:0]                 layer_idx,
  output logic [3:0]                 neuron_idx,
  output logic [3:0]                 chunk_idx,
  output logic [ADDR_W-1:0]          w_addr,
  output logic [PARALLEL_INPUTS-1:0] lane_mask,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic                       act_en,
  output logic                       out_valid,
  input  logic                       out_ready
);
  seq_state_t r_state, w_next;
  logic [7:0] r_drain;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0] w_chunk, w_neuron;
  logic [1:0] w_layer;
  logic w_chunk_term, w_neuron_term, w_layer_term;
  logic w_accept, w_run, w_beat, w_layer_end, w_drain_end;
  logic [3:0] w_chunk_lim [N_LAYERS];
  logic [3:0] w_neuron_lim [N_LAYERS];
  logic [PARALLEL_INPUTS-1:0] w_tail_mask [N_LAYERS];

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_tbl
    assign w_chunk_lim[g] = 4'(chunks(FANIN[g], PARALLEL_INPUTS) - 1);
    assign w_neuron_lim[g] = 4'(FANOUT[g] - 1);
    assign w_tail_mask[g] = (FANIN[g] % PARALLEL_INPUTS == 0) ? '1
      : PARALLEL_INPUTS'((1 << (FANIN[g] % PARALLEL_INPUTS)) - 1);
  end

  assign w_accept = in_valid & in_ready;
  assign w_run = r_state == RUN;
  assign w_beat = w_run & mac_ready;
  assign w_layer_end = w_beat & w_chunk_term & w_neuron_term;
  assign w_drain_end = (r_state == DRAIN) && (r_drain == 8'(MAC_LAT - 1));

  dpd_loop_counter #(.W(4)) u_chunk (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_beat),
    .i_limit(w_chunk_lim[w_layer]), .o_count(w_chunk), .o_term(w_chunk_term)
  );
  dpd_loop_counter #(.W(4)) u_neuron (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_beat & w_chunk_term),
    .i_limit(w_neuron_lim[w_layer]), .o_count(w_neuron), .o_term(w_neuron_term)
  );
  // Layer advances only once its results have landed, so it is stable through DRAIN
  dpd_loop_counter #(.W(2)) u_layer (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_drain_end),
    .i_limit(2'(N_LAYERS - 1)), .o_count(w_layer), .o_term(w_layer_term)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = (r_state == IDLE) ? (in_valid ? RUN : IDLE)
      : (r_state == RUN) ? (w_layer_end ? DRAIN : RUN)
      : (r_state == DRAIN) ? (w_drain_end ? (w_layer_term ? DONE : RUN) : DRAIN)
      : (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain <= '0;
      r_addr <= '0;
    end else begin
      r_drain <= (r_state == DRAIN && !w_drain_end) ? r_drain + 8'd1 : '0;
      r_addr <= w_accept ? '0 : w_beat ? r_addr + 1'b1 : r_addr;
    end
  end

  // Chunk-major loop order makes the flat weight address a plain running beat count
  always_comb begin
    in_ready = (r_state == IDLE) & ~rst;
    mac_valid = w_run;
    out_valid = r_state == DONE;
    layer_idx = w_layer;
    neuron_idx = w_neuron;
    chunk_idx = w_chunk;
    w_addr = r_addr;
    acc_first = w_run & (w_chunk == '0);
    acc_last = w_run & w_chunk_term;
    act_en = w_run & (int'(w_layer) < N_LAYERS - 1);
    lane_mask = !w_run ? '0 : w_chunk_term ? w_tail_mask[w_layer] : '1;
  end
endmodule
